// File: rtl/management_tx_frame_buffer.sv
// Transmit frame buffer for the mgmt0 management port. Firmware bytes are packed big-endian into
// 32-bit words, held until committed, then played out back to back toward the mgmt0 MAC.
module management_tx_frame_buffer #(
    parameter int DEPTH      = 512,
    parameter int MAX_FRAMES = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [7:0]                  wr_data,
    input  logic                        wr_commit,
    input  logic                        wr_drop,
    output logic [$clog2(DEPTH):0]      wr_space,
    output logic                        wr_overflow,
    output logic [$clog2(MAX_FRAMES):0] frames_pending,
    input  logic                        tx_ready,
    // EthernetTxBus flattened: {start, data_valid, bytes_valid[2:0], data[31:0]}
    output logic [36:0]                 tx_bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int QW = $clog2(MAX_FRAMES);
    localparam int LW = 11;
    localparam logic [LW-1:0] MAX_LEN = 11'd2047;
    localparam logic [PW-1:0] DEPTH_W = PW'(DEPTH);
    localparam logic [QW:0]   MAXF_W  = (QW+1)'(MAX_FRAMES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        GAP   = 2'd3
    } tx_state_t;

    logic [31:0]   mem_r [DEPTH];
    logic [LW-1:0] len_q_r [MAX_FRAMES];
    logic [31:0]   rdata_r;

    // write side state
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_commit_ptr_r;
    logic [1:0]    lane_r;
    logic [31:0]   pack_word_r;
    logic [LW-1:0] frame_len_r;
    logic          overflow_r;
    logic [QW:0]   lq_wptr_r;

    // transmit side state
    tx_state_t     state_r;
    tx_state_t     state_nxt_s;
    logic [PW-1:0] rd_ptr_r;
    logic [AW-1:0] rd_addr_r;
    logic [AW-1:0] rd_addr_s;
    logic [QW:0]   lq_rptr_r;
    logic [LW-1:0] cur_len_r;
    logic [9:0]    sent_r;
    logic [9:0]    nwords_s;
    logic [2:0]    last_bv_s;

    logic          tx_start_r;
    logic          tx_valid_r;
    logic [2:0]    tx_bv_r;
    logic [31:0]   tx_data_r;
    logic          start_nxt_s;
    logic          valid_nxt_s;
    logic [2:0]    bv_nxt_s;
    logic [31:0]   data_nxt_s;
    logic          ld_len_s;
    logic          pop_s;

    logic [PW-1:0]     wr_space_r;
    logic [QW:0]       frames_pending_r;

    logic          no_room_s;
    logic          len_full_s;
    logic          lq_full_s;
    logic          byte_try_s;
    logic          set_ovf_s;
    logic          byte_ok_s;
    logic [1:0]    lane_inc_s;
    logic [LW-1:0] len_nxt_s;
    logic          commit_drop_s;
    logic          commit_ok_s;
    logic          rewind_s;
    logic          ram_we_s;
    logic [31:0]   base_s;
    logic [31:0]   word_s;
    logic [PW-1:0] wr_ptr_nxt_s;

    // Write-side decode: a new word needs a free slot only when its first byte arrives.
    always_comb begin
        no_room_s     = (lane_r == 2'd0) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0])
                        && (wr_ptr_r[AW] != rd_ptr_r[AW]);
        len_full_s    = (frame_len_r == MAX_LEN);
        lq_full_s     = ((lq_wptr_r - lq_rptr_r) == MAXF_W);
        byte_try_s    = wr_en & ~wr_drop & ~overflow_r;
        set_ovf_s     = byte_try_s & (no_room_s | len_full_s);
        byte_ok_s     = byte_try_s & ~no_room_s & ~len_full_s;
        lane_inc_s    = lane_r + {1'b0, byte_ok_s};
        len_nxt_s     = frame_len_r + {{(LW-1){1'b0}}, byte_ok_s};
        commit_drop_s = wr_commit & ~wr_drop & (overflow_r | set_ovf_s | lq_full_s);
        commit_ok_s   = wr_commit & ~wr_drop & ~commit_drop_s & (len_nxt_s != {LW{1'b0}});
        rewind_s      = wr_drop | commit_drop_s;
        ram_we_s      = ~rewind_s & ((byte_ok_s & (lane_r == 2'd3))
                        | (commit_ok_s & (lane_inc_s != 2'd0)));
        wr_ptr_nxt_s  = ram_we_s ? (wr_ptr_r + {{(PW-1){1'b0}}, 1'b1}) : wr_ptr_r;
    end

    // Byte packer: a fresh word starts from zero so unused low bytes of a short last word read 0.
    always_comb begin
        base_s = (lane_r == 2'd0) ? 32'd0 : pack_word_r;
        word_s = base_s;
        if (byte_ok_s) begin
            case (lane_r)
                2'd0:    word_s = {wr_data, base_s[23:0]};
                2'd1:    word_s = {base_s[31:24], wr_data, base_s[15:0]};
                2'd2:    word_s = {base_s[31:16], wr_data, base_s[7:0]};
                2'd3:    word_s = {base_s[31:8], wr_data};
                default: word_s = base_s;
            endcase
        end else begin
            word_s = base_s;
        end
    end

    // Write pointers, lane counter, frame length and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r        <= {PW{1'b0}};
            wr_commit_ptr_r <= {PW{1'b0}};
            lane_r          <= 2'd0;
            pack_word_r     <= 32'd0;
            frame_len_r     <= {LW{1'b0}};
            overflow_r      <= 1'b0;
            lq_wptr_r       <= {(QW+1){1'b0}};
        end else if (rewind_s) begin
            wr_ptr_r    <= wr_commit_ptr_r;
            lane_r      <= 2'd0;
            frame_len_r <= {LW{1'b0}};
            overflow_r  <= 1'b0;
        end else if (commit_ok_s) begin
            wr_ptr_r        <= wr_ptr_nxt_s;
            wr_commit_ptr_r <= wr_ptr_nxt_s;
            lane_r          <= 2'd0;
            frame_len_r     <= {LW{1'b0}};
            overflow_r      <= 1'b0;
            lq_wptr_r       <= lq_wptr_r + {{QW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            lane_r      <= lane_inc_s;
            frame_len_r <= len_nxt_s;
            pack_word_r <= word_s;
            if (set_ovf_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Frame RAM, length queue and synchronous read port.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= word_s;
        end
        if (commit_ok_s) begin
            len_q_r[lq_wptr_r[QW-1:0]] <= len_nxt_s;
        end
        rdata_r <= mem_r[rd_addr_s];
    end

    // Word count and last-word lane count of the frame being sent.
    always_comb begin
        nwords_s  = {1'b0, cur_len_r[10:2]} + {9'd0, (cur_len_r[1:0] != 2'd0)};
        last_bv_s = (cur_len_r[1:0] == 2'd0) ? 3'd4 : {1'b0, cur_len_r[1:0]};
    end

    // TX next-state and next bus values; the bus is registered so values are one state ahead.
    always_comb begin
        state_nxt_s = state_r;
        rd_addr_s   = rd_addr_r;
        ld_len_s    = 1'b0;
        pop_s       = 1'b0;
        start_nxt_s = 1'b0;
        valid_nxt_s = 1'b0;
        bv_nxt_s    = 3'd0;
        data_nxt_s  = 32'd0;
        case (state_r)
            IDLE: begin
                rd_addr_s = rd_ptr_r[AW-1:0];
                if ((frames_pending_r != {(QW+1){1'b0}}) && tx_ready) begin
                    state_nxt_s = START;
                    ld_len_s    = 1'b1;
                    start_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                state_nxt_s = DATA;
                valid_nxt_s = 1'b1;
                data_nxt_s  = rdata_r;
                bv_nxt_s    = (nwords_s == 10'd1) ? last_bv_s : 3'd4;
            end
            DATA: begin
                if (sent_r == nwords_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = GAP;
                end else begin
                    state_nxt_s = DATA;
                    valid_nxt_s = 1'b1;
                    data_nxt_s  = rdata_r;
                    bv_nxt_s    = ((sent_r + 10'd1) == nwords_s) ? last_bv_s : 3'd4;
                end
            end
            GAP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // TX state register and registered bus outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            tx_start_r <= 1'b0;
            tx_valid_r <= 1'b0;
            tx_bv_r    <= 3'd0;
            tx_data_r  <= 32'd0;
        end else begin
            state_r    <= state_nxt_s;
            tx_start_r <= start_nxt_s;
            tx_valid_r <= valid_nxt_s;
            tx_bv_r    <= bv_nxt_s;
            tx_data_r  <= data_nxt_s;
        end
    end

    // Read pointers, prefetch address and per-frame counters; a finished frame frees its words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r  <= {PW{1'b0}};
            rd_addr_r <= {AW{1'b0}};
            lq_rptr_r <= {(QW+1){1'b0}};
            cur_len_r <= {LW{1'b0}};
            sent_r    <= 10'd0;
        end else begin
            rd_addr_r <= rd_addr_s + {{(AW-1){1'b0}}, 1'b1};
            if (ld_len_s) begin
                cur_len_r <= len_q_r[lq_rptr_r[QW-1:0]];
            end
            if (valid_nxt_s) begin
                sent_r <= (state_r == START) ? 10'd1 : (sent_r + 10'd1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + PW'(nwords_s);
                lq_rptr_r <= lq_rptr_r + {{QW{1'b0}}, 1'b1};
            end
        end
    end

    // Status outputs lag the pointers by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_space_r       <= DEPTH_W;
            frames_pending_r <= {(QW+1){1'b0}};
        end else begin
            wr_space_r       <= DEPTH_W - (wr_ptr_r - rd_ptr_r);
            frames_pending_r <= lq_wptr_r - lq_rptr_r;
        end
    end

    assign wr_space       = wr_space_r;
    assign wr_overflow    = overflow_r;
    assign frames_pending = frames_pending_r;
    assign tx_bus         = {tx_start_r, tx_valid_r, tx_bv_r, tx_data_r};

endmodule

// File: tb/tb_management_tx_frame_buffer.sv
// Self-checking bench for management_tx_frame_buffer: expected words are queued at commit and
// compared as the DUT plays them out, alongside direct status and reset checks.
module tb_management_tx_frame_buffer;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        wr_commit;
    logic        wr_drop;
    logic [9:0]  wr_space;
    logic        wr_overflow;
    logic [4:0]  frames_pending;
    logic        tx_ready;
    logic [36:0] tx_bus;

    int n_checks = 0;
    int n_pass   = 0;

    // {last, bytes_valid[2:0], data[31:0]}
    logic [35:0] exp_q[$];
    logic [35:0] mon_e;
    logic        exp_more, exp_idle, ready_d, valid_d;

    always #5 clk = ~clk;

    management_tx_frame_buffer #(.DEPTH(512), .MAX_FRAMES(16)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .wr_commit(wr_commit),
        .wr_drop(wr_drop), .wr_space(wr_space), .wr_overflow(wr_overflow),
        .frames_pending(frames_pending), .tx_ready(tx_ready), .tx_bus(tx_bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_expected(input int len, input int base);
        for (int w = 0; w * 4 < len; w++) begin
            logic [31:0] d;
            int          bv;
            d = 32'd0;
            for (int k = 0; k < 4; k++) begin
                if (w * 4 + k < len) d[31 - 8 * k -: 8] = 8'(base + w * 4 + k);
            end
            bv = (len - w * 4 >= 4) ? 4 : (len - w * 4);
            exp_q.push_back({(w * 4 + 4 >= len), 3'(bv), d});
        end
    endtask

    // mode 0: commit on the cycle after the last byte, 1: commit with the last byte, 2: no commit
    task automatic write_frame(input int len, input int base, input int mode);
        for (int i = 0; i < len; i++) begin
            wr_en     = 1'b1;
            wr_data   = 8'(base + i);
            wr_commit = (mode == 1) && (i == len - 1);
            tick(1);
        end
        wr_en     = 1'b0;
        wr_commit = 1'b0;
        if (mode == 0) begin
            wr_commit = 1'b1;
            tick(1);
            wr_commit = 1'b0;
        end
        if (mode != 2) push_expected(len, base);
    endtask

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(1);
            c++;
        end
        check_val("drain", exp_q.size(), 32'd0);
        tick(4);
    endtask

    // Output monitor: pops the scoreboard on each data word and checks framing rules.
    always @(negedge clk) begin
        if (rst) begin
            exp_more <= 1'b0;
            exp_idle <= 1'b0;
            ready_d  <= 1'b0;
            valid_d  <= 1'b0;
        end else begin
            if (exp_more) check_val("back_to_back", 32'(tx_bus[35]), 32'd1);
            if (exp_idle) check_val("gap_after_last", 32'(tx_bus[35]), 32'd0);
            if (tx_bus[35]) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_word", exp_q.size(), 32'd1);
                    exp_more <= 1'b0;
                    exp_idle <= 1'b0;
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("tx_data", tx_bus[31:0], mon_e[31:0]);
                    check_val("tx_bytes_valid", 32'(tx_bus[34:32]), 32'(mon_e[34:32]));
                    exp_more <= !mon_e[35];
                    exp_idle <= mon_e[35];
                end
            end else begin
                exp_more <= 1'b0;
                exp_idle <= 1'b0;
            end
            if (tx_bus[36]) begin
                check_val("start_ready", 32'(ready_d), 32'd1);
                check_val("start_gap", 32'(valid_d), 32'd0);
                check_val("start_no_valid", 32'(tx_bus[35]), 32'd0);
                exp_more <= 1'b1;
            end
            ready_d <= tx_ready;
            valid_d <= tx_bus[35];
        end
    end

    initial begin
        int c;
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'd0; wr_commit = 1'b0; wr_drop = 1'b0; tx_ready = 1'b1;
        tick(3);
        check_val("rst_space", 32'(wr_space), 32'd512);
        check_val("rst_pending", 32'(frames_pending), 32'd0);
        check_val("rst_overflow", 32'(wr_overflow), 32'd0);
        check_val("rst_bus_data", tx_bus[31:0], 32'd0);
        check_val("rst_bus_ctl", 32'(tx_bus[36:32]), 32'd0);
        rst = 1'b0;
        tick(2);

        // 60-byte frame with latency check
        write_frame(60, 8'h00, 0);
        tick(1);
        check_val("pending_after_commit", 32'(frames_pending), 32'd1);
        tick(1);
        check_val("start_latency", 32'(tx_bus[36]), 32'd1);
        wait_drain(100);

        // 61-byte frame, short last word
        write_frame(61, 8'h00, 0);
        tick(1);
        check_val("pending_61", 32'(frames_pending), 32'd1);
        wait_drain(100);
        check_val("pending_61_done", 32'(frames_pending), 32'd0);

        // dropped partial frame then 5-byte frame
        write_frame(10, 8'h90, 2);
        check_val("space_partial", 32'(wr_space), 32'd510);
        wr_drop = 1'b1;
        tick(1);
        wr_drop = 1'b0;
        tick(2);
        check_val("space_after_drop", 32'(wr_space), 32'd512);
        write_frame(5, 8'hAA, 0);
        wait_drain(50);

        // fill to DEPTH words with the MAC held off, then overflow
        tx_ready = 1'b0;
        write_frame(2044, 8'h00, 0);
        write_frame(4, 8'h20, 1);
        tick(2);
        check_val("space_full", 32'(wr_space), 32'd0);
        check_val("pending_full", 32'(frames_pending), 32'd2);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick(1);
        wr_en = 1'b0;
        check_val("overflow_set", 32'(wr_overflow), 32'd1);
        wr_commit = 1'b1;
        tick(1);
        wr_commit = 1'b0;
        check_val("overflow_clear", 32'(wr_overflow), 32'd0);
        tick(2);
        check_val("pending_unchanged", 32'(frames_pending), 32'd2);
        tx_ready = 1'b1;
        wait_drain(1500);
        check_val("space_drained", 32'(wr_space), 32'd512);

        // three queued frames with a toggling ready
        tx_ready = 1'b0;
        write_frame(5, 8'h10, 0);
        write_frame(8, 8'h40, 1);
        write_frame(7, 8'h80, 0);
        tick(2);
        check_val("pending_three", 32'(frames_pending), 32'd3);
        for (int i = 0; i < 200; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
        tx_ready = 1'b1;
        wait_drain(200);
        check_val("pending_three_done", 32'(frames_pending), 32'd0);

        // reset in the middle of DATA
        write_frame(40, 8'h50, 0);
        c = 0;
        while (!tx_bus[35] && c < 20) begin
            tick(1);
            c++;
        end
        check_val("reached_data", 32'(tx_bus[35]), 32'd1);
        tick(2);
        #2;
        rst = 1'b1;
        #1;
        check_val("midrst_bus_data", tx_bus[31:0], 32'd0);
        check_val("midrst_bus_ctl", 32'(tx_bus[36:32]), 32'd0);
        check_val("midrst_space", 32'(wr_space), 32'd512);
        check_val("midrst_pending", 32'(frames_pending), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(2);
        write_frame(7, 8'hC0, 0);
        wait_drain(50);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
